// File: rtl/note_seq_pkg.sv
// Shared constants for the note sequencer: FSM state codes and song ROM entry layout.
package note_seq_pkg;

   localparam int unsigned NOTE_W   = 8;
   localparam int unsigned DUR_W    = 16;
   localparam int unsigned NOTE_LSB = DUR_W;

   // An entry whose duration field equals this value terminates the song.
   localparam int unsigned TERM_DURATION = 0;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_WAIT_DATA = 3'd2;
   localparam logic [2:0] S_PLAY      = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;

endpackage

// File: rtl/note_sequencer_if.sv
// Bus between the note sequencer, its song ROM, its control source and the note voice.
interface note_sequencer_if
   import note_seq_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DUR_WIDTH  = 16
);
   logic                          start;
   logic                          stop;
   logic                          loop_en;
   logic [ADDR_WIDTH-1:0]         song_base;
   logic [ADDR_WIDTH-1:0]         rom_addr;
   logic                          rom_rd_en;
   logic [NOTE_W+DUR_WIDTH-1:0]   rom_data;
   logic [NOTE_W-1:0]             noteid;
   logic                          note_strobe;
   logic                          busy;
   logic                          done;

   modport master (
      input  start, stop, loop_en, song_base, rom_data,
      output rom_addr, rom_rd_en, noteid, note_strobe, busy, done
   );

   modport slave (
      output start, stop, loop_en, song_base, rom_data,
      input  rom_addr, rom_rd_en, noteid, note_strobe, busy, done
   );
endinterface

// File: rtl/tick_timer.sv
// Tick prescaler plus duration down-counter; o_expire_c flags the last cycle of a loaded interval.
module tick_timer #(
   parameter int unsigned TICK_CYCLES = 120_000,
   parameter int unsigned DUR_WIDTH   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [DUR_WIDTH-1:0] i_ticks,
   output logic                 o_expire_c
);
   localparam int unsigned    PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

   logic [PRE_W-1:0]     r_pre;
   logic [DUR_WIDTH-1:0] r_ticks;
   logic                 w_tick_end;

   assign w_tick_end = (r_pre == PRE_LAST);
   assign o_expire_c = w_tick_end && (r_ticks == DUR_WIDTH'(1));

   // A load restarts the prescaler so partial ticks never carry over.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pre   <= '0;
         r_ticks <= '0;
      end else if (i_load) begin
         r_pre   <= '0;
         r_ticks <= i_ticks;
      end else if (r_ticks != '0) begin
         if (w_tick_end) begin
            r_pre   <= '0;
            r_ticks <= r_ticks - DUR_WIDTH'(1);
         end else begin
            r_pre   <= r_pre + PRE_W'(1);
         end
      end
   end
endmodule

// File: rtl/note_sequencer.sv
// Melody player: walks {noteid, duration} entries of a song ROM and drives the note voice,
// inserting a silent gap after each note so repeated notes retrigger.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 120_000,
   parameter int unsigned GAP_TICKS   = 10,
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DUR_WIDTH   = DUR_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   note_sequencer_if.master bus
);
   localparam int unsigned NOTE_OFS = NOTE_LSB + DUR_WIDTH - DUR_W;
   localparam logic        HAS_GAP  = (GAP_TICKS != 0);

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] w_ptr_nxt;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic                  r_rd_en;
   logic                  w_rd_en_nxt;
   logic [NOTE_W-1:0]     r_noteid;
   logic [NOTE_W-1:0]     w_noteid_nxt;
   logic                  r_strobe;
   logic                  w_strobe_nxt;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_done_nxt;
   logic                  w_load;
   logic [DUR_WIDTH-1:0]  w_load_ticks;
   logic                  w_expire;
   logic [DUR_WIDTH-1:0]  w_dur;
   logic [NOTE_W-1:0]     w_note;

   assign w_dur  = bus.rom_data[DUR_WIDTH-1:0];
   assign w_note = bus.rom_data[NOTE_OFS +: NOTE_W];

   tick_timer #(
      .TICK_CYCLES (TICK_CYCLES),
      .DUR_WIDTH   (DUR_WIDTH)
   ) u_tick_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_ticks    (w_load_ticks),
      .o_expire_c (w_expire)
   );

   // Next-state and next-output logic; stop overrides everything in a non-idle state.
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_addr_nxt   = r_rom_addr;
      w_rd_en_nxt  = 1'b0;
      w_noteid_nxt = r_noteid;
      w_strobe_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      w_load       = 1'b0;
      w_load_ticks = w_dur;

      if ((r_state != S_IDLE) && bus.stop) begin
         w_state_nxt  = S_IDLE;
         w_noteid_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && !bus.stop) begin
                  w_ptr_nxt   = bus.song_base;
                  w_addr_nxt  = bus.song_base;
                  w_rd_en_nxt = 1'b1;
                  w_state_nxt = S_FETCH;
               end
            end
            S_FETCH: begin
               w_state_nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
               if (w_dur == DUR_WIDTH'(TERM_DURATION)) begin
                  if (bus.loop_en) begin
                     w_ptr_nxt   = bus.song_base;
                     w_addr_nxt  = bus.song_base;
                     w_rd_en_nxt = 1'b1;
                     w_state_nxt = S_FETCH;
                  end else begin
                     w_done_nxt   = 1'b1;
                     w_noteid_nxt = '0;
                     w_state_nxt  = S_IDLE;
                  end
               end else begin
                  w_noteid_nxt = w_note;
                  w_strobe_nxt = 1'b1;
                  w_load       = 1'b1;
                  w_load_ticks = w_dur;
                  w_ptr_nxt    = r_ptr + ADDR_WIDTH'(1);
                  w_state_nxt  = S_PLAY;
               end
            end
            S_PLAY: begin
               if (w_expire) begin
                  if (HAS_GAP) begin
                     w_noteid_nxt = '0;
                     w_load       = 1'b1;
                     w_load_ticks = DUR_WIDTH'(GAP_TICKS);
                     w_state_nxt  = S_GAP;
                  end else begin
                     w_addr_nxt  = r_ptr;
                     w_rd_en_nxt = 1'b1;
                     w_state_nxt = S_FETCH;
                  end
               end
            end
            S_GAP: begin
               if (w_expire) begin
                  w_addr_nxt  = r_ptr;
                  w_rd_en_nxt = 1'b1;
                  w_state_nxt = S_FETCH;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_rom_addr <= '0;
         r_rd_en    <= 1'b0;
         r_noteid   <= '0;
         r_strobe   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_rom_addr <= w_addr_nxt;
         r_rd_en    <= w_rd_en_nxt;
         r_noteid   <= w_noteid_nxt;
         r_strobe   <= w_strobe_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= w_done_nxt;
      end
   end

   assign bus.rom_addr    = r_rom_addr;
   assign bus.rom_rd_en   = r_rd_en;
   assign bus.noteid      = r_noteid;
   assign bus.note_strobe = r_strobe;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
endmodule
